// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing definitions.
//   - Default 640x480@60 timing constants (25 MHz pixel rate from a 50 MHz clock).
//   - phase_t: blanking phase of one axis (visible, front porch, sync, back porch).
//   - axis_total(): derives the H/V total from the four phase lengths.
package vga_pkg;

  typedef enum logic [1:0] {VIS, FP, SYNC, BP} phase_t;

  function automatic int axis_total(input int visible, input int front,
                                    input int sync_len, input int back);
    return visible + front + sync_len + back;
  endfunction

  localparam int DEF_C_SIZE    = 9;
  localparam int DEF_CLK_DIV   = 2;
  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int DEF_H_TOTAL = axis_total(DEF_H_VISIBLE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
  localparam int DEF_V_TOTAL = axis_total(DEF_V_VISIBLE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: position counter plus phase FSM for one VGA axis.
// Ports:
//   clock     in   system clock
//   reset     in   asynchronous reset, active-low
//   enable    in   advance the counter by one position this clock
//   count     out  current position, 0..TOTAL-1
//   count_nxt out  position the counter takes at the next clock edge
//   phase     out  current phase (vga_pkg::phase_t encoding)
//   wrap      out  high while enabled on the last position (counter returns to 0)
//   sync_n    out  low while the axis is in its sync phase
module vga_axis_counter #(
  parameter int VISIBLE = 640,
  parameter int FRONT   = 16,
  parameter int SYNC    = 96,
  parameter int BACK    = 48,
  parameter int W       = 10
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         enable,
  output logic [W-1:0] count,
  output logic [W-1:0] count_nxt,
  output logic [1:0]   phase,
  output logic         wrap,
  output logic         sync_n
);

  localparam int TOTAL = vga_pkg::axis_total(VISIBLE, FRONT, SYNC, BACK);

  localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
  localparam logic [W-1:0] FP_START   = W'(VISIBLE);
  localparam logic [W-1:0] SYNC_START = W'(VISIBLE + FRONT);
  localparam logic [W-1:0] BP_START   = W'(VISIBLE + FRONT + SYNC);

  vga_pkg::phase_t state, state_nxt;

  assign wrap = enable && (count == LAST);

  always_comb begin
    count_nxt = count;
    if (enable) count_nxt = wrap ? '0 : count + W'(1);
  end

  // The phase follows the position the counter is entering, so state and
  // count change on the same edge. Later phases are tested first so that a
  // zero-length phase is skipped rather than stuck in.
  always_comb begin
    state_nxt = state;
    if (enable) begin
      if (count_nxt == '0)              state_nxt = vga_pkg::VIS;
      else if (count_nxt == BP_START)   state_nxt = vga_pkg::BP;
      else if (count_nxt == SYNC_START) state_nxt = vga_pkg::SYNC;
      else if (count_nxt == FP_START)   state_nxt = vga_pkg::FP;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
      state <= vga_pkg::VIS;
    end else begin
      count <= count_nxt;
      state <= state_nxt;
    end
  end

  assign phase  = state;
  assign sync_n = (state != vga_pkg::SYNC);

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA timing generator driving the RGB pixel stage.
// Optional feature macro: VGA_FRAME_STROBE_EN (adds the frame_start port).
// Ports:
//   clock       in   system clock
//   reset       in   asynchronous reset, active-low
//   hsync       out  horizontal sync, active-low
//   vsync       out  vertical sync, active-low
//   disp_enable out  high inside the visible area
//   row         out  current line, 0..V_TOTAL-1
//   column      out  current pixel, 0..H_TOTAL-1
//   frame_start out  one-clock pulse when (row,column) becomes (0,0)
//                    (only with VGA_FRAME_STROBE_EN)
// row/column/disp_enable change together; hsync/vsync trail them by one
// clock so they line up with the pixel stage's registered RGB outputs.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int C_SIZE    = DEF_C_SIZE,
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK
) (
  input  logic          clock,
  input  logic          reset,
  output logic          hsync,
  output logic          vsync,
  output logic          disp_enable,
  output logic [C_SIZE:0] row,
  output logic [C_SIZE:0] column
`ifdef VGA_FRAME_STROBE_EN
  ,
  output logic          frame_start
`endif
);

  localparam int W       = C_SIZE + 1;
  localparam int H_TOTAL = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [W:0]       H_VIS_L  = (W + 1)'(H_VISIBLE);
  localparam logic [W:0]       V_VIS_L  = (W + 1)'(V_VISIBLE);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_sync_gen: CLK_DIV must be >= 1");
  end
  if (H_TOTAL > (1 << W)) begin : g_bad_htotal
    $error("vga_sync_gen: H_TOTAL does not fit in C_SIZE+1 bits");
  end
  if (V_TOTAL > (1 << W)) begin : g_bad_vtotal
    $error("vga_sync_gen: V_TOTAL does not fit in C_SIZE+1 bits");
  end

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [W-1:0]     h_count, h_nxt, v_count, v_nxt;
  logic [1:0]       h_phase, v_phase;
  logic             h_wrap, v_wrap, h_sync_n, v_sync_n;

  // With CLK_DIV=1 div_cnt stays 0 and tick is permanently high.
  assign tick = (div_cnt == DIV_LAST);

  vga_axis_counter #(
    .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .W(W)
  ) u_h (
    .clock(clock), .reset(reset), .enable(tick),
    .count(h_count), .count_nxt(h_nxt), .phase(h_phase),
    .wrap(h_wrap), .sync_n(h_sync_n)
  );

  // The vertical axis steps once per line, on the tick that wraps the column.
  vga_axis_counter #(
    .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .W(W)
  ) u_v (
    .clock(clock), .reset(reset), .enable(h_wrap),
    .count(v_count), .count_nxt(v_nxt), .phase(v_phase),
    .wrap(v_wrap), .sync_n(v_sync_n)
  );

  // Counters are registers already; disp_enable is computed from the next
  // positions so it registers on the same edge as row/column.
  assign column = h_count;
  assign row    = v_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_cnt     <= '0;
      disp_enable <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
    end else begin
      div_cnt     <= tick ? '0 : div_cnt + DIV_W'(1);
      disp_enable <= ({1'b0, h_nxt} < H_VIS_L) && ({1'b0, v_nxt} < V_VIS_L);
      hsync       <= h_sync_n;
      vsync       <= v_sync_n;
    end
  end

`ifdef VGA_FRAME_STROBE_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) frame_start <= 1'b0;
    else        frame_start <= h_wrap && v_wrap;
  end
`endif

  logic unused_status;
  assign unused_status = ^{h_phase, v_phase, v_wrap};

endmodule

// File: tb/tb_vga_sync_gen.sv
module tb_vga_sync_gen;

  localparam int CS = 4;
  localparam int CD = 3;
  localparam int HV = 8, HF = 2, HS = 3, HB = 2;
  localparam int VV = 5, VF = 1, VS = 2, VB = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        hsync, vsync, disp_enable;
  logic [CS:0] row, column;
`ifdef VGA_FRAME_STROBE_EN
  logic        frame_start;
`endif

  int total = 0;
  int bad   = 0;

  vga_sync_gen #(
    .C_SIZE(CS), .CLK_DIV(CD),
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clock(clock), .reset(reset),
    .hsync(hsync), .vsync(vsync), .disp_enable(disp_enable),
    .row(row), .column(column)
`ifdef VGA_FRAME_STROBE_EN
    , .frame_start(frame_start)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Screen position (linear pixel index within the frame) after t clock
  // edges since reset release: one pixel per CD clocks.
  function automatic int pos_at(input int t);
    return (t / CD) % (HT * VT);
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, ".hsync"}, {31'd0, hsync}, 1);
    check({tag, ".vsync"}, {31'd0, vsync}, 1);
    check({tag, ".de"}, {31'd0, disp_enable}, 0);
    check({tag, ".row"}, {27'd0, row}, 0);
    check({tag, ".col"}, {27'd0, column}, 0);
`ifdef VGA_FRAME_STROBE_EN
    check({tag, ".fs"}, {31'd0, frame_start}, 0);
`endif
  endtask

  task automatic check_running(input int t);
    int p, c, r, pp, pc, pr;
    int e_de, e_hs, e_vs;
    if (t == 0) begin
      check_reset_state("t0");
      return;
    end
    p  = pos_at(t);
    c  = p % HT;
    r  = p / HT;
    pp = pos_at(t - 1);
    pc = pp % HT;
    pr = pp / HT;
    e_de = (c < HV && r < VV) ? 1 : 0;
    e_hs = (pc >= HV + HF && pc < HV + HF + HS) ? 0 : 1;
    e_vs = (pr >= VV + VF && pr < VV + VF + VS) ? 0 : 1;
    check("col", {27'd0, column}, c);
    check("row", {27'd0, row}, r);
    check("de", {31'd0, disp_enable}, e_de);
    check("hsync", {31'd0, hsync}, e_hs);
    check("vsync", {31'd0, vsync}, e_vs);
`ifdef VGA_FRAME_STROBE_EN
    check("fs", {31'd0, frame_start}, (t % CD == 0 && p == 0) ? 1 : 0);
`endif
  endtask

  initial begin
    int n;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_state("por");

    for (int seg = 0; seg < 6; seg++) begin
      @(negedge clock);
      reset = 1'b1;
      check_running(0);
      n = (seg == 0) ? 3 * HT * VT * CD + 7 : int'($urandom_range(40, 1200));
      for (int t = 1; t <= n; t++) begin
        @(negedge clock);
        check_running(t);
      end
      // Asynchronous assertion between edges: outputs must clear at once.
      #($urandom_range(1, 3));
      reset = 1'b0;
      #1;
      check_reset_state("async");
      for (int k = 0; k < 5; k++) begin
        @(negedge clock);
        check_reset_state("held");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
